// File: rtl/univ_register_pkg.sv
// rtl/univ_register_pkg.sv - shared encodings for the universal register
// Shift modes, shift directions and sequencer states.
package univ_register_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ROT = 2'b01;
  localparam logic [1:0] MODE_ARI = 2'b10;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_step.sv
// rtl/univ_shift_step.sv - combinational single-bit shifter
// Shared by the sr/sl path and the shift-by-N sequencer.
module univ_shift_step
  import univ_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data,
  output logic             o_out_bit
);

  logic w_fill_bit;

  always_comb begin
    w_fill_bit = i_fill;
    o_data     = i_data;
    o_out_bit  = 1'b0;
    if (i_dir == DIR_R) begin
      case (i_mode)
        MODE_ROT: w_fill_bit = i_data[0];
        MODE_ARI: w_fill_bit = i_data[WIDTH-1];
        default:  w_fill_bit = i_fill;
      endcase
      o_data    = {w_fill_bit, i_data[WIDTH-1:1]};
      o_out_bit = i_data[0];
    end else begin
      // Arithmetic left shift is the same as logical with a forced zero fill.
      case (i_mode)
        MODE_ROT: w_fill_bit = i_data[WIDTH-1];
        MODE_ARI: w_fill_bit = 1'b0;
        default:  w_fill_bit = i_fill;
      endcase
      o_data    = {i_data[WIDTH-2:0], w_fill_bit};
      o_out_bit = i_data[WIDTH-1];
    end
  end

endmodule

// File: rtl/univ_register.sv
// rtl/univ_register.sv - universal working/accumulator register
// Clear/load/inc/dec/shift with saturation option and a shift-by-N sequencer.
module univ_register
  import univ_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             sl,
  input  logic             ir,
  input  logic             il,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             so,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic [WIDTH-1:0] r_out;
  logic             r_co;
  logic             r_so;
  logic             r_busy;
  logic             r_done;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir;
  logic [1:0]       r_mode;
  state_t           r_state;

  logic             w_step_dir;
  logic [1:0]       w_step_mode;
  logic             w_step_fill;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_bit;
  logic             w_all1;
  logic             w_is0;

  assign w_all1 = (r_out == ALL1);
  assign w_is0  = (r_out == '0);

  // The sequencer uses its latched controls; in IDLE sr wins over sl.
  assign w_step_dir  = (r_state == ST_SHIFT) ? r_dir  : (sr ? DIR_R : DIR_L);
  assign w_step_mode = (r_state == ST_SHIFT) ? r_mode : mode;
  assign w_step_fill = (w_step_dir == DIR_R) ? ir : il;

  univ_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_data   (r_out),
    .i_dir    (w_step_dir),
    .i_mode   (w_step_mode),
    .i_fill   (w_step_fill),
    .o_data   (w_step_data),
    .o_out_bit(w_step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_co    <= 1'b0;
      r_so    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_dir   <= DIR_R;
      r_mode  <= MODE_LOG;
      r_state <= ST_IDLE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cl) begin
            r_out <= '0;
            r_co  <= 1'b0;
            r_so  <= 1'b0;
          end else if (start) begin
            if (amt != '0) begin
              r_cnt   <= amt;
              r_dir   <= dir;
              r_mode  <= mode;
              r_busy  <= 1'b1;
              r_state <= ST_SHIFT;
            end else begin
              r_done <= 1'b1;
            end
          end else if (ld) begin
            r_out <= in;
          end else if (inc) begin
            r_co <= w_all1;
            if (!(SAT && w_all1)) r_out <= r_out + ONE;
          end else if (dec) begin
            r_co <= w_is0;
            if (!(SAT && w_is0)) r_out <= r_out - ONE;
          end else if (sr || sl) begin
            r_out <= w_step_data;
            r_so  <= w_step_bit;
          end
        end
        ST_SHIFT: begin
          // Abort: cleared like cl, and no done pulse is produced.
          if (cl) begin
            r_out   <= '0;
            r_co    <= 1'b0;
            r_so    <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_out <= w_step_data;
            r_so  <= w_step_bit;
            r_cnt <= r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out  = r_out;
  assign co   = r_co;
  assign so   = r_so;
  assign busy = r_busy;
  assign done = r_done;
  assign zero = (r_out == '0);

endmodule
